// File: rtl/video_sync_gen_if.sv
// Timing bus of the video sync generator: PROM port, pixel enable and the
// decoded raster timing consumed by the playfield, motion-object and IRQ logic.
interface video_sync_gen_if;
  logic       pix_ce;
  logic [7:0] prom_a;
  logic       prom_e1;
  logic       prom_e2;
  logic [3:0] prom_d;
  logic [8:0] hcount;
  logic [7:0] vcount;
  logic       hsync;
  logic       hblank;
  logic       vsync;
  logic       vblank;
  logic       irq;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  pix_ce, prom_d,
    output prom_a, prom_e1, prom_e2, hcount, vcount, hsync, hblank,
           vsync, vblank, irq, line_start, frame_start
  );

  modport slave (
    output pix_ce, prom_d,
    input  prom_a, prom_e1, prom_e2, hcount, vcount, hsync, hblank,
           vsync, vblank, irq, line_start, frame_start
  );
endinterface

// File: rtl/video_sync_gen.sv
// Master raster counter: horizontal timing decoded from hcount compares,
// vertical timing taken from a registered 256x4 PROM addressed by vcount.
module video_sync_gen #(
  parameter int H_TOTAL  = 384,
  parameter int HB_START = 256,
  parameter int HB_END   = 0,
  parameter int HS_START = 296,
  parameter int HS_END   = 328,
  parameter int H_VDEC   = 2,
  parameter int V_TOTAL  = 256
) (
  input  logic clk,
  input  logic reset,
  video_sync_gen_if.master bus
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [7:0] V_LAST = 8'(V_TOTAL - 1);
  localparam logic [8:0] HS_S   = 9'(HS_START);
  localparam logic [8:0] HS_E   = 9'(HS_END);
  localparam logic [8:0] HB_S   = 9'(HB_START);
  localparam logic [8:0] H_DEC  = 9'(H_VDEC);

  logic [8:0] hcount_q, h_next;
  logic [7:0] vcount_q, v_next;
  logic       h_wrap, v_wrap;
  logic       hsync_q, hsync_next;
  logic       hblank_q, hblank_next;
  logic       vsync_q, vblank_q, hist_q, irq_q;
  logic       line_start_q, frame_start_q;
  logic       sample;
  logic       unused;

  always_comb begin
    h_wrap     = (hcount_q == H_LAST);
    v_wrap     = (vcount_q == V_LAST);
    h_next     = h_wrap ? 9'd0 : hcount_q + 9'd1;
    v_next     = vcount_q;
    if (h_wrap) v_next = v_wrap ? 8'd0 : vcount_q + 8'd1;
    hsync_next = (h_next >= HS_S) && (h_next < HS_E);
    // hcount==H_VDEC is at least one clock after prom_a last moved.
    sample     = bus.pix_ce && (hcount_q == H_DEC);
  end

  // A zero HB_END means blanking ends exactly at the wrap, so no low compare.
  generate
    if (HB_END == 0) begin : g_hb_plain
      assign hblank_next = (h_next >= HB_S);
    end else begin : g_hb_wrap
      localparam logic [8:0] HB_E = 9'(HB_END);
      assign hblank_next = (h_next >= HB_S) || (h_next < HB_E);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q      <= 9'd0;
      vcount_q      <= 8'd0;
      hsync_q       <= 1'b0;
      hblank_q      <= 1'b0;
      vsync_q       <= 1'b0;
      vblank_q      <= 1'b0;
      hist_q        <= 1'b0;
      irq_q         <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      irq_q         <= 1'b0;
      if (bus.pix_ce) begin
        hcount_q      <= h_next;
        vcount_q      <= v_next;
        hsync_q       <= hsync_next;
        hblank_q      <= hblank_next;
        line_start_q  <= h_wrap;
        frame_start_q <= h_wrap && v_wrap;
      end
      if (sample) begin
        vsync_q  <= bus.prom_d[1];
        vblank_q <= bus.prom_d[2];
        hist_q   <= bus.prom_d[0];
        irq_q    <= bus.prom_d[0] && !hist_q;
      end
    end
  end

  assign unused          = bus.prom_d[3];
  assign bus.prom_a      = vcount_q;
  assign bus.prom_e1     = !reset;
  assign bus.prom_e2     = !reset;
  assign bus.hcount      = hcount_q;
  assign bus.vcount      = vcount_q;
  assign bus.hsync       = hsync_q;
  assign bus.hblank      = hblank_q;
  assign bus.vsync       = vsync_q;
  assign bus.vblank      = vblank_q;
  assign bus.irq         = irq_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen: a short-line instance for frame/PROM/IRQ timing and
// a default-parameter instance for full-width line timing.
module tb_video_sync_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_ce = 1'b1;
  always #5 clk = ~clk;

  video_sync_gen_if s_if ();
  video_sync_gen_if b_if ();

  assign s_if.pix_ce = pix_ce;
  assign b_if.pix_ce = pix_ce;
  assign b_if.prom_d = 4'd0;

  video_sync_gen #(
    .H_TOTAL(64), .HB_START(44), .HB_END(0), .HS_START(48), .HS_END(56),
    .H_VDEC(2), .V_TOTAL(256)
  ) u_small (.clk(clk), .reset(reset), .bus(s_if.master));

  video_sync_gen u_big (.clk(clk), .reset(reset), .bus(b_if.master));

  // PROM contents: vblank lines dc..fe, vsync lines e7..f2, IRQ line(s) selectable.
  logic [7:0] irq_a = 8'h5e;
  logic       dbl   = 1'b0;

  function automatic logic [3:0] rom(input logic [7:0] a);
    logic [3:0] d;
    d = 4'b0000;
    if (a >= 8'hdc && a <= 8'hfe) d[2] = 1'b1;
    if (a >= 8'he7 && a <= 8'hf2) d[1] = 1'b1;
    if (a == irq_a || (dbl && a == irq_a + 8'd1)) d[0] = 1'b1;
    return d;
  endfunction

  always @(posedge clk) s_if.prom_d <= rom(s_if.prom_a);

  // Scoreboard state
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference raster model
  logic [8:0] mh = '0, bh = '0;
  logic [7:0] mv = '0, bv = '0;
  logic mhist = 0, mvs = 0, mvb = 0, mirq = 0, mls = 0, mfs = 0, bls = 0;

  // Per-phase statistics
  int s_bad, b_bad, b_hs_n, b_hb_n, b_ls_n, b_ls_t0, b_ls_t1, s_irq_n, s_irq_extra, s_fs_n;
  logic [8:0] b_hs_min, b_hs_max;
  logic [16:0] vb_rise, vs_rise, vs_fall, s_fs_cur;
  logic [7:0] s_fs_pv;
  logic vb_seen, vs_rseen, vs_fseen;
  logic s_pvb = 0, s_pvs = 0;
  logic [7:0] s_pv = '0;

  task automatic clear_stats();
    s_bad = 0; b_bad = 0; b_hs_n = 0; b_hb_n = 0; b_ls_n = 0; b_ls_t0 = 0; b_ls_t1 = 0;
    s_irq_n = 0; s_irq_extra = 0; s_fs_n = 0;
    b_hs_min = 9'h1ff; b_hs_max = 9'h000;
    vb_rise = '0; vs_rise = '0; vs_fall = '0; s_fs_cur = '1; s_fs_pv = '0;
    vb_seen = 0; vs_rseen = 0; vs_fseen = 0;
  endtask

  task automatic tick();
    logic ce, rs;
    logic [3:0] d;
    ce = pix_ce;
    rs = reset;
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      mh = '0; mv = '0; bh = '0; bv = '0;
      mhist = 0; mvs = 0; mvb = 0; mirq = 0; mls = 0; mfs = 0; bls = 0;
    end else begin
      mirq = 0; mls = 0; mfs = 0; bls = 0;
      if (ce) begin
        if (mh == 9'd2) begin
          d = rom(mv);
          mvs = d[1]; mvb = d[2];
          mirq = d[0] && !mhist;
          mhist = d[0];
        end
        if (mh == 9'd63) begin
          mh = '0; mls = 1; mfs = (mv == 8'hff); mv = mv + 8'd1;
        end else mh = mh + 9'd1;
        if (bh == 9'd383) begin
          bh = '0; bls = 1; bv = bv + 8'd1;
        end else bh = bh + 9'd1;
      end
    end
    if ({s_if.hcount, s_if.vcount, s_if.prom_a, s_if.hsync, s_if.hblank, s_if.vsync,
         s_if.vblank, s_if.irq, s_if.line_start, s_if.frame_start, s_if.prom_e1, s_if.prom_e2}
        !== {mh, mv, mv, (mh >= 9'd48 && mh < 9'd56), (mh >= 9'd44), mvs, mvb, mirq, mls, mfs,
             !rs, !rs})
      s_bad++;
    if ({b_if.hcount, b_if.vcount, b_if.hsync, b_if.hblank, b_if.vsync, b_if.vblank,
         b_if.irq, b_if.line_start, b_if.frame_start}
        !== {bh, bv, (bh >= 9'd296 && bh < 9'd328), (bh >= 9'd256), 1'b0, 1'b0, 1'b0, bls, 1'b0})
      b_bad++;
    if (b_if.hsync === 1'b1) begin
      b_hs_n++;
      if (bh < b_hs_min) b_hs_min = bh;
      if (bh > b_hs_max) b_hs_max = bh;
    end
    if (b_if.hblank === 1'b1) b_hb_n++;
    if (b_if.line_start === 1'b1) begin
      if (b_ls_n == 0) b_ls_t0 = cyc;
      b_ls_t1 = cyc;
      b_ls_n++;
    end
    if (s_if.irq === 1'b1) begin
      s_irq_n++;
      if (exp_q.size() == 0) s_irq_extra++;
      else check("irq_line", {24'd0, s_if.vcount}, {24'd0, exp_q.pop_front()});
    end
    if (s_if.vblank === 1'b1 && !s_pvb && !vb_seen) begin vb_seen = 1; vb_rise = {mv, mh}; end
    if (s_if.vsync === 1'b1 && !s_pvs && !vs_rseen) begin vs_rseen = 1; vs_rise = {mv, mh}; end
    if (s_if.vsync === 1'b0 && s_pvs && !vs_fseen) begin vs_fseen = 1; vs_fall = {mv, mh}; end
    if (s_if.frame_start === 1'b1) begin
      s_fs_n++;
      s_fs_pv = s_pv;
      s_fs_cur = {s_if.vcount, s_if.hcount};
    end
    s_pvb = s_if.vblank;
    s_pvs = s_if.vsync;
    s_pv  = s_if.vcount;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clear_stats();
    // Reset with pix_ce high: reset wins.
    reset = 1'b1; pix_ce = 1'b1;
    ticks(3);
    check("rst_hcount", {23'd0, s_if.hcount}, 32'd0);
    check("rst_vcount", {24'd0, s_if.vcount}, 32'd0);
    check("rst_outs", {s_if.hsync, s_if.hblank, s_if.vsync, s_if.vblank, s_if.irq,
                       s_if.line_start, s_if.frame_start, s_if.prom_a}, 32'd0);
    check("rst_prom_e", {s_if.prom_e1, s_if.prom_e2, b_if.prom_e1, b_if.prom_e2}, 32'd0);
    check("rst_big_h", {23'd0, b_if.hcount}, 32'd0);

    // Two full 384-pixel lines on the default instance.
    reset = 1'b0;
    clear_stats();
    ticks(768);
    check("line_hsync_clks", b_hs_n, 64);
    check("line_hsync_first", {23'd0, b_hs_min}, 296);
    check("line_hsync_last", {23'd0, b_hs_max}, 327);
    check("line_hblank_clks", b_hb_n, 256);
    check("line_start_count", b_ls_n, 2);
    check("line_start_space", b_ls_t1 - b_ls_t0, 384);
    check("prom_e_run", {s_if.prom_e1, s_if.prom_e2}, 32'h3);
    check("model_small_p1", s_bad, 0);
    check("model_big_p1", b_bad, 0);

    // One full frame on the short-line instance: wrap, PROM decode, single IRQ.
    clear_stats();
    exp_q.push_back(8'h5e);
    ticks(16384);
    check("frame_start_count", s_fs_n, 1);
    check("frame_start_prev_v", {24'd0, s_fs_pv}, 32'hff);
    check("frame_start_pos", {15'd0, s_fs_cur}, 32'd0);
    check("vblank_rise", {15'd0, vb_rise}, {15'd0, 8'hdc, 9'd3});
    check("vsync_rise", {15'd0, vs_rise}, {15'd0, 8'he7, 9'd3});
    check("vsync_fall", {15'd0, vs_fall}, {15'd0, 8'hf3, 9'd3});
    check("irq_count_p2", s_irq_n, 1);
    check("irq_missing_p2", exp_q.size(), 0);
    check("irq_extra_p2", s_irq_extra, 0);
    check("model_small_p2", s_bad, 0);
    check("model_big_p2", b_bad, 0);

    // IRQ bit set on two consecutive lines still yields one pulse.
    clear_stats();
    dbl = 1'b1;
    exp_q.push_back(8'h5e);
    ticks(16384);
    check("irq_count_dbl", s_irq_n, 1);
    check("irq_missing_dbl", exp_q.size(), 0);
    check("irq_extra_dbl", s_irq_extra, 0);
    check("model_small_p3", s_bad, 0);
    dbl = 1'b0;

    // Reset inside vertical sync clears everything on the same edge.
    clear_stats();
    for (int i = 0; i < 20000 && !(mv == 8'he9 && mh == 9'd10); i++) tick();
    check("seek_line_e9", {15'd0, mv, mh}, {15'd0, 8'he9, 9'd10});
    check("pre_rst_vsync", {31'd0, s_if.vsync}, 32'd1);
    check("pre_rst_vblank", {31'd0, s_if.vblank}, 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_clear", {s_if.hcount, s_if.vcount, s_if.hsync, s_if.hblank, s_if.vsync,
                            s_if.vblank, s_if.irq, s_if.line_start, s_if.frame_start}, 32'd0);
    check("mid_rst_prom_e", {s_if.prom_e1, s_if.prom_e2}, 32'd0);
    ticks(2);
    reset = 1'b0;
    ticks(200);
    check("model_small_p4", s_bad, 0);
    check("model_big_p4", b_bad, 0);

    // Pixel enable every 4th clock.
    irq_a = 8'h01;
    reset = 1'b1; pix_ce = 1'b1;
    ticks(3);
    reset = 1'b0;
    clear_stats();
    exp_q.push_back(8'h01);
    for (int i = 0; i < 3100; i++) begin
      pix_ce = (i % 4 == 0);
      tick();
    end
    check("ce4_line_start_clks", b_ls_n, 2);
    check("ce4_line_start_space", b_ls_t1 - b_ls_t0, 1536);
    check("ce4_irq_clks", s_irq_n, 1);
    check("ce4_irq_missing", exp_q.size(), 0);
    check("model_small_p5", s_bad, 0);
    check("model_big_p5", b_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
